axis_video_bridge: RTL and testbench

Parametrised AXI4-Stream video master with an internal pixel FIFO and frame framing. It accepts raw RGB pixels from the enhancement datapath through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It emits them as AXI4-Stream beats with TUSER marking start-of-frame and TLAST marking end-of-line, for a frame size latched at `start`. It sits between the datapath output and the chip's stream output port.

---
 rtl/axis_video_bridge.sv | 166 ++++++++++++++++
 tb/tb_axis_video_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_bridge.sv
// ============================================================================
// axis_video_bridge
// Pixel valid/ready input -> FIFO -> AXI4-Stream video master (TUSER=SOF, TLAST=EOL).
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_video_bridge #(
    parameter int DATA_W  = 24,
    parameter int TDATA_W = 32,
    parameter int DEPTH   = 8,
    parameter int DIM_W   = 11
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     i_start,
    input  logic [DIM_W-1:0]         i_img_width,
    input  logic [DIM_W-1:0]         i_img_height,
    input  logic [DATA_W-1:0]        i_pix_in,
    input  logic                     i_pix_valid,
    output logic                     o_pix_ready,
    output logic [TDATA_W-1:0]       o_tdata,
    output logic                     o_tvalid,
    input  logic                     i_tready,
    output logic                     o_tlast,
    output logic                     o_tuser,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DIM_W-1:0]   r_width;
    logic [DIM_W-1:0]   r_height;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_frame_done;

    logic               w_full;
    logic               w_empty;
    logic               w_pix_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_col_end;
    logic               w_row_end;
    logic               w_last_pix;
    logic               w_final_beat;
    logic               w_start_ok;
    logic [ENT_W-1:0]   w_head;
    logic [ENT_W-1:0]   w_wr_entry;

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_pix_ready = (r_state == S_ACTIVE) && !w_full;
    assign w_push      = i_pix_valid && w_pix_ready;
    assign w_pop       = !w_empty && i_tready;
    assign w_col_end   = (r_col == r_width - DIM_W'(1));
    assign w_row_end   = (r_row == r_height - DIM_W'(1));
    assign w_last_pix  = w_push && w_col_end && w_row_end;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_wr_entry  = {(r_col == '0) && (r_row == '0), w_col_end, i_pix_in};

    // Once every frame pixel is in the FIFO, the entry popped at count 1 is the frame's last beat.
    assign w_final_beat = (r_state == S_DRAIN) && w_pop && (r_count == c_ONE) && w_head[DATA_W];

    // The frame_done cycle still rejects start so a new frame needs a clean IDLE cycle.
    assign w_start_ok = i_start && !r_frame_done &&
                        (i_img_width != '0) && (i_img_height != '0);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_final_beat;

            if ((r_state == S_IDLE) && w_start_ok) begin
                r_width  <= i_img_width;
                r_height <= i_img_height;
                r_col    <= '0;
                r_row    <= '0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy/pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_tdata      = '0;
        o_tvalid     = !w_empty;
        o_tlast      = 1'b0;
        o_tuser      = 1'b0;
        o_pix_ready  = w_pix_ready;
        o_fifo_count = r_count;
        o_busy       = (r_state != S_IDLE);
        o_frame_done = r_frame_done;

        case (r_state)
            S_IDLE:   if (w_start_ok)   w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_last_pix)   w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_final_beat) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase

        if (!w_empty) begin
            o_tdata[DATA_W-1:0] = w_head[DATA_W-1:0];
            o_tlast             = w_head[DATA_W];
            o_tuser             = w_head[DATA_W+1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_video_bridge.sv
// ============================================================================
// tb_axis_video_bridge
// Directed self-checking bench for axis_video_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_video_bridge;

    localparam int DATA_W  = 24;
    localparam int TDATA_W = 32;
    localparam int DEPTH   = 8;
    localparam int DIM_W   = 11;
    localparam int MAXB    = 64;

    logic                   clk = 1'b0;
    logic                   resetN = 1'b0;
    logic                   i_start = 1'b0;
    logic [DIM_W-1:0]       i_img_width = '0;
    logic [DIM_W-1:0]       i_img_height = '0;
    logic [DATA_W-1:0]      i_pix_in = '0;
    logic                   i_pix_valid = 1'b0;
    logic                   i_tready = 1'b0;
    logic                   o_pix_ready;
    logic [TDATA_W-1:0]     o_tdata;
    logic                   o_tvalid;
    logic                   o_tlast;
    logic                   o_tuser;
    logic [$clog2(DEPTH):0] o_fifo_count;
    logic                   o_busy;
    logic                   o_frame_done;

    axis_video_bridge #(
        .DATA_W(DATA_W), .TDATA_W(TDATA_W), .DEPTH(DEPTH), .DIM_W(DIM_W)
    ) u_dut (
        .clk(clk), .resetN(resetN), .i_start(i_start),
        .i_img_width(i_img_width), .i_img_height(i_img_height),
        .i_pix_in(i_pix_in), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
        .o_tlast(o_tlast), .o_tuser(o_tuser), .o_fifo_count(o_fifo_count),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int                 n_chk = 0;
    int                 n_bad = 0;
    int                 n_acc, n_beats, n_fd, max_cnt, cyc_no;
    logic [DATA_W-1:0]  base;
    logic [TDATA_W-1:0] bd [MAXB];
    logic               bl [MAXB];
    logic               bu [MAXB];
    int                 bcyc [MAXB];
    bit                 stab_en = 1'b1;
    bit                 prev_stall = 1'b0;
    logic [TDATA_W+1:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, then advance past the next posedge.
    task automatic cyc(input logic vld, input logic rdy);
        i_pix_valid = vld;
        i_tready    = rdy;
        i_pix_in    = base + DATA_W'(n_acc);
        @(negedge clk);
        if (stab_en && prev_stall)
            chk("hold", {o_tvalid, o_tuser, o_tlast, o_tdata}, {1'b1, prev_out});
        prev_stall = o_tvalid && !i_tready;
        prev_out   = {o_tuser, o_tlast, o_tdata};
        if (int'(o_fifo_count) > max_cnt) max_cnt = int'(o_fifo_count);
        if (o_frame_done) begin
            n_fd++;
            chk("busy_at_done", {63'd0, o_busy}, 64'd0);
        end
        if (i_pix_valid && o_pix_ready) n_acc++;
        if (o_tvalid && i_tready && n_beats < MAXB) begin
            bd[n_beats]   = o_tdata;
            bl[n_beats]   = o_tlast;
            bu[n_beats]   = o_tuser;
            bcyc[n_beats] = cyc_no;
            n_beats++;
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic new_frame(input int w, input int h, input logic [DATA_W-1:0] b);
        n_acc = 0; n_beats = 0; n_fd = 0; max_cnt = 0; base = b;
        i_img_width  = DIM_W'(w);
        i_img_height = DIM_W'(h);
        i_start = 1'b1;
        cyc(1'b0, 1'b0);
        i_start = 1'b0;
    endtask

    task automatic run(input int mode, input int budget);
        for (int k = 0; k < budget && n_fd == 0; k++) begin
            if (mode == 0) cyc(1'b1, 1'b1);
            else           cyc(((k / 4) % 2) == 0, ((k / 8) % 2) == 1);
        end
        if (n_fd == 0) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic check_beats(input int w, input int h);
        chk("beat_count", 64'(n_beats), 64'(w * h));
        for (int i = 0; i < n_beats; i++) begin
            chk($sformatf("data%0d", i), 64'(bd[i]), 64'({8'h00, base + DATA_W'(i)}));
            chk($sformatf("user%0d", i), 64'(bu[i]), 64'(i == 0));
            chk($sformatf("last%0d", i), 64'(bl[i]), 64'((i % w) == w - 1));
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_pix_ready"},  64'(o_pix_ready),  64'd0);
        chk({pfx, "_tvalid"},     64'(o_tvalid),     64'd0);
        chk({pfx, "_tdata"},      64'(o_tdata),      64'd0);
        chk({pfx, "_tlast"},      64'(o_tlast),      64'd0);
        chk({pfx, "_tuser"},      64'(o_tuser),      64'd0);
        chk({pfx, "_fifo_count"}, 64'(o_fifo_count), 64'd0);
        chk({pfx, "_busy"},       64'(o_busy),       64'd0);
        chk({pfx, "_frame_done"}, 64'(o_frame_done), 64'd0);
    endtask

    initial begin
        n_acc = 0; n_beats = 0; n_fd = 0; max_cnt = 0; cyc_no = 0; base = '0;
        prev_out = '0;
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        check_idle_outputs("reset");
        resetN = 1'b1;

        // 2x2 streaming at full rate
        new_frame(2, 2, 24'h010000);
        run(0, 50);
        check_beats(2, 2);
        for (int i = 1; i < n_beats; i++)
            chk($sformatf("consec%0d", i), 64'(bcyc[i] - bcyc[i-1]), 64'd1);
        chk("max_cnt_le1", 64'(max_cnt <= 1), 64'd1);
        chk("t1_busy_after", 64'(o_busy), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        chk("t1_fd_once", 64'(n_fd), 64'd1);

        // 4x4 against a stalled sink fills the FIFO
        new_frame(4, 4, 24'h100000);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        chk("t2_accepted", 64'(n_acc), 64'd8);
        chk("t2_count", 64'(o_fifo_count), 64'd8);
        chk("t2_pix_ready", 64'(o_pix_ready), 64'd0);
        chk("t2_tvalid", 64'(o_tvalid), 64'd1);
        chk("t2_head", 64'(o_tdata), 64'h0010_0000);
        run(0, 100);
        check_beats(4, 4);

        // 4x3 with gapped input and bursty sink
        new_frame(4, 3, 24'h200000);
        run(1, 400);
        check_beats(4, 3);

        // zero-width start is ignored, then 1x1
        new_frame(0, 3, 24'h300000);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        chk("t4_busy", 64'(o_busy), 64'd0);
        chk("t4_pix_ready", 64'(o_pix_ready), 64'd0);
        chk("t4_no_beats", 64'(n_beats), 64'd0);
        new_frame(1, 1, 24'h310000);
        run(0, 50);
        check_beats(1, 1);

        // mid-frame reset with 5 entries buffered
        new_frame(4, 4, 24'h400000);
        for (int i = 0; i < 20 && n_acc < 5; i++) cyc(1'b1, 1'b0);
        chk("t5_count", 64'(o_fifo_count), 64'd5);
        stab_en = 1'b0;
        resetN = 1'b0;
        cyc(1'b0, 1'b0);
        resetN = 1'b1;
        check_idle_outputs("midreset");
        prev_stall = 1'b0;
        stab_en = 1'b1;
        new_frame(2, 2, 24'h500000);
        run(0, 50);
        check_beats(2, 2);

        // start during ACTIVE with other dimensions is ignored
        new_frame(2, 3, 24'h600000);
        cyc(1'b1, 1'b1);
        i_img_width = 11'd3; i_img_height = 11'd3; i_start = 1'b1;
        cyc(1'b1, 1'b1);
        i_start = 1'b0;
        run(0, 60);
        check_beats(2, 3);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        chk("t6_fd_once", 64'(n_fd), 64'd1);
        chk("t6_idle_busy", 64'(o_busy), 64'd0);
        chk("t6_no_extra", 64'(n_beats), 64'd6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
